pll_mode_seq: RTL
=================

PLL_MODE_SEQ -- requirements
Module: pll_mode_seq

Interface
REQ-001 Parameter NUM_MODES, default 2, number of selectable PLL profiles (2..8).
REQ-002 Parameter SEL_W, default 1, mode-select width; SHALL equal ceil(log2(NUM_MODES)).
REQ-003 Parameter STABLE_CYCLES, default 2, consecutive equal samples required before mode_sel is accepted (1..15).
REQ-004 Parameter GAP_CYCLES, default 3, idle cycles between management writes (0..15).
REQ-005 Parameter LOCK_TIMEOUT, default 65535, maximum cycles to wait for locked after the start write.
REQ-006 Parameters MODE_ADDR=0, K_ADDR=7, START_ADDR=2: management register addresses (6 bits each).
REQ-007 clk_50m  in  1  sole clock; all logic on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 mode_sel  in  SEL_W  requested profile, asynchronous to clk_50m.
REQ-010 mode_k  in  NUM_MODES*32  fractional-K word per profile; profile i occupies bits [32i+31:32i]; static.
REQ-011 locked  in  1  PLL lock indication, asynchronous.
REQ-012 mgmt_waitrequest  in  1  reconfig controller busy; a write is accepted on the cycle it is low.
REQ-013 mgmt_write  out  1  write strobe.
REQ-014 mgmt_address  out  6  register address.
REQ-015 mgmt_writedata  out  32  register data.
REQ-016 busy  out  1  high from sequence start until DONE/ERR is left.
REQ-017 applied_mode  out  SEL_W  last profile written to the PLL.
REQ-018 done  out  1  one-cycle pulse on successful completion.
REQ-019 lock_err  out  1  sticky lock-timeout flag.

Function
REQ-020 mode_sel and locked SHALL pass through 2-flop synchronisers before use.
REQ-021 Synchronised mode_sel is accepted as stable_sel after STABLE_CYCLES identical consecutive samples; any change restarts the count.
REQ-022 stable_sel values >= NUM_MODES SHALL be ignored; no sequence starts.
REQ-023 States: IDLE, WR_MODE, GAP1, WR_K, GAP2, WR_START, WAIT_LOCK, DONE, ERR.
REQ-024 IDLE -> WR_MODE when stable_sel != applied_mode and stable_sel is valid; target latched at that edge.
REQ-025 WR_MODE: address MODE_ADDR, data 0. WR_K: address K_ADDR, data mode_k slice of target. WR_START: address START_ADDR, data 0.
REQ-026 In each WR_* state mgmt_write SHALL be high and address/data stable until the cycle mgmt_waitrequest is low; the next state is entered on the following edge.
REQ-027 mgmt_write SHALL be low in every non-WR_* state; at most one accepted write per WR_* state.
REQ-028 GAP1/GAP2 last exactly GAP_CYCLES cycles (0 = pass-through in one cycle).
REQ-029 applied_mode SHALL update to target on acceptance of the WR_K write.
REQ-030 WAIT_LOCK: wait GAP_CYCLES, then wait for synchronised locked high; a 1-cycle high -> DONE; counter reaching LOCK_TIMEOUT -> ERR.
REQ-031 DONE: done=1 for one cycle, lock_err cleared, -> IDLE. ERR: lock_err set, -> IDLE, no done pulse.
REQ-032 Changes to mode_sel while busy SHALL NOT abort the sequence; the latest stable value is re-evaluated in IDLE (latest wins, intermediate values dropped).
REQ-033 busy SHALL be high in every state except IDLE.
REQ-034 After ERR, no retry occurs until stable_sel changes to a value different from applied_mode.

Reset
REQ-035 On reset low, asynchronously: state IDLE, mgmt_write 0, mgmt_address 0, mgmt_writedata 0, busy 0, done 0, lock_err 0, applied_mode 0, counters and synchronisers 0.
REQ-036 Reset asserted mid-sequence SHALL abort immediately; after release, a sequence starts again once stable_sel != 0.
REQ-037 After release with mode_sel held at 0, no management write SHALL occur.

Verification
REQ-038 NUM_MODES=2, mode_sel 0->1, waitrequest low, locked high: writes (0,0),(7,mode_k[63:32]),(2,0) separated by 3 idle cycles; done pulses once; applied_mode=1.
REQ-039 waitrequest held high 10 cycles during WR_K: mgmt_write, address 7 and data held stable for all 11 cycles, single acceptance, sequence continues.
REQ-040 mode_sel glitch 0->1->0 lasting 1 cycle with STABLE_CYCLES=2: no writes, busy stays 0.
REQ-041 NUM_MODES=4, mode_sel 1 then 3 during GAP1: sequence for mode 1 completes with done, then a second full sequence writes mode_k[127:96]; applied_mode=3.
REQ-042 LOCK_TIMEOUT=100, locked held low: ERR after 100 WAIT_LOCK cycles, lock_err=1, no done; a subsequent successful sequence clears lock_err.
REQ-043 Reset pulse during GAP2: all outputs 0 within the reset cycle; after release with mode_sel=1, full sequence restarts from WR_MODE.

Source files
------------

// File: rtl/pll_mode_seq.sv
// -----------------------------------------------------------------------------
// pll_mode_seq
//
// Reprograms a PLL through its reconfiguration management port whenever the
// (debounced) mode_sel input asks for a profile different from the one last
// written. Each change issues three management writes (mode register,
// fractional-K word of the selected profile, start), separated by idle gaps,
// and then waits for the PLL to lock with a timeout.
//
// Ports
//   clk_50m           in   sole clock, rising edge
//   reset             in   asynchronous, active-low reset
//   mode_sel          in   requested profile (asynchronous to clk_50m)
//   mode_k            in   fractional-K word per profile, profile i at [32i+31:32i]
//   locked            in   PLL lock indication (asynchronous)
//   mgmt_waitrequest  in   reconfig controller busy; write accepted when low
//   mgmt_write        out  management write strobe
//   mgmt_address      out  management register address
//   mgmt_writedata    out  management register data
//   busy              out  high whenever a sequence is in progress
//   applied_mode      out  last profile whose K word was written to the PLL
//   done              out  one-cycle pulse on successful lock
//   lock_err          out  sticky lock-timeout flag, cleared by next success
// -----------------------------------------------------------------------------
module pll_mode_seq #(
    parameter int         NUM_MODES     = 2,
    parameter int         SEL_W         = 1,
    parameter int         STABLE_CYCLES = 2,
    parameter int         GAP_CYCLES    = 3,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter logic [5:0] MODE_ADDR     = 6'd0,
    parameter logic [5:0] K_ADDR        = 6'd7,
    parameter logic [5:0] START_ADDR    = 6'd2
) (
    input  logic                    clk_50m,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        mode_sel,
    input  logic [NUM_MODES*32-1:0] mode_k,
    input  logic                    locked,
    input  logic                    mgmt_waitrequest,
    output logic                    mgmt_write,
    output logic [5:0]              mgmt_address,
    output logic [31:0]             mgmt_writedata,
    output logic                    busy,
    output logic [SEL_W-1:0]        applied_mode,
    output logic                    done,
    output logic                    lock_err
);

    localparam int          SEL_SPAN  = 1 << SEL_W;
    localparam logic [3:0]  STABLE_N  = 4'(STABLE_CYCLES);
    localparam logic [31:0] GAP_U     = 32'(GAP_CYCLES);
    localparam logic [31:0] TIMEOUT_U = 32'(LOCK_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_GAP1,
        S_WR_K,
        S_GAP2,
        S_WR_START,
        S_WAIT_LOCK,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_next;
    logic [SEL_W-1:0] sel_meta, sel_sync;
    logic             lock_meta, lock_sync;
    logic [SEL_W-1:0] sel_cand, stable_sel;
    logic [3:0]       run_cnt;
    logic [SEL_W-1:0] target;
    logic [31:0]      cnt;
    logic [SEL_SPAN-1:0] valid_map;
    logic             sel_valid;
    logic             gap_done, lock_window, lock_timeout;

    // Two-flop synchronisers for the asynchronous inputs.
    // NOTE: reset is asynchronous (in the sensitivity list) and every flop in
    // the design is cleared by it, so no output depends on a first clock edge.
    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            sel_meta  <= '0;
            sel_sync  <= '0;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its source.
            sel_meta  <= mode_sel;
            sel_sync  <= sel_meta;
            lock_meta <= locked;
            lock_sync <= lock_meta;
        end
    end

    // Debounce: sel_cand is the value being observed, run_cnt how many
    // consecutive samples it has been seen. It becomes stable_sel on the
    // STABLE_CYCLES-th identical sample; any change restarts the run at 1.
    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            sel_cand   <= '0;
            run_cnt    <= '0;
            stable_sel <= '0;
        end else if (sel_sync != sel_cand) begin
            sel_cand <= sel_sync;
            run_cnt  <= 4'd1;
            if (STABLE_CYCLES == 1) stable_sel <= sel_sync;
        end else if (run_cnt < STABLE_N) begin
            run_cnt <= run_cnt + 4'd1;
            if (run_cnt + 4'd1 == STABLE_N) stable_sel <= sel_cand;
        end
    end

    // Selector codes at or above NUM_MODES name no profile and are ignored.
    always_comb begin
        for (int i = 0; i < SEL_SPAN; i++) valid_map[i] = (i < NUM_MODES);
    end
    assign sel_valid = valid_map[stable_sel];

    // cnt counts cycles spent in the current state. Gaps last GAP_CYCLES
    // cycles but never less than one. WAIT_LOCK ignores locked during its
    // first GAP_CYCLES cycles and gives up after LOCK_TIMEOUT cycles in total.
    assign gap_done     = (cnt + 32'd1 >= GAP_U);
    assign lock_window  = (cnt >= GAP_U);
    assign lock_timeout = (cnt + 32'd1 >= TIMEOUT_U);

    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_next     = state;
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        unique case (state)
            S_IDLE: begin
                if (sel_valid && (stable_sel != applied_mode)) state_next = S_WR_MODE;
            end
            S_WR_MODE: begin
                mgmt_write   = 1'b1;
                mgmt_address = MODE_ADDR;
                if (!mgmt_waitrequest) state_next = S_GAP1;
            end
            S_GAP1: begin
                if (gap_done) state_next = S_WR_K;
            end
            S_WR_K: begin
                mgmt_write     = 1'b1;
                mgmt_address   = K_ADDR;
                mgmt_writedata = mode_k[32*int'(target) +: 32];
                if (!mgmt_waitrequest) state_next = S_GAP2;
            end
            S_GAP2: begin
                if (gap_done) state_next = S_WR_START;
            end
            S_WR_START: begin
                mgmt_write   = 1'b1;
                mgmt_address = START_ADDR;
                if (!mgmt_waitrequest) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_window && lock_sync) state_next = S_DONE;
                else if (lock_timeout)        state_next = S_ERR;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            target       <= '0;
            applied_mode <= '0;
            lock_err     <= 1'b0;
        end else begin
            if ((state_next != state) || (state == S_IDLE)) cnt <= '0;
            else                                            cnt <= cnt + 32'd1;
            // The profile is frozen at sequence start; later mode_sel changes
            // are only looked at again once the sequence is back in IDLE.
            if ((state == S_IDLE) && (state_next == S_WR_MODE)) target <= stable_sel;
            if ((state == S_WR_K) && !mgmt_waitrequest) applied_mode <= target;
            if (state == S_DONE) lock_err <= 1'b0;
            if (state == S_ERR)  lock_err <= 1'b1;
        end
    end

endmodule
